// File: rtl/ifetch_queue.sv
// Instruction fetch unit: requests cache lines, buffers one line and streams its words into a small queue.
// Optional stall counter output o_perf_starve_cnt is built when IFETCH_PERF_CNT_EN is defined.
module ifetch_queue #(
  parameter int                ADDR_W         = 30,
  parameter int                WORDS_PER_LINE = 4,
  parameter int                FIFO_DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_redirect_valid,
  input  logic [ADDR_W-1:0]                          i_redirect_pc,
  output logic                                       o_req_valid,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0]   o_req_addr,
  input  logic                                       i_req_ready,
  input  logic                                       i_resp_valid,
  input  logic [32*WORDS_PER_LINE-1:0]               i_resp_data,
  output logic                                       o_out_valid,
  input  logic                                       i_out_ready,
  output logic [ADDR_W-1:0]                          o_out_pc,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]                                o_perf_starve_cnt,
`endif
  output logic [31:0]                                o_out_insn
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_RUN, S_FLUSH} state_t;

  state_t r_state, w_state_next;

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_line [WORDS_PER_LINE];
  logic [LINE_W-1:0] r_line_tag;
  logic              r_line_valid;
  logic [ADDR_W-1:0] r_q_pc   [FIFO_DEPTH];
  logic [31:0]       r_q_insn [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W:0]    r_count;

  logic [31:0]       w_resp_words [WORDS_PER_LINE];
  logic [OFF_W-1:0]  w_off;
  logic [31:0]       w_push_insn;
  logic              w_last, w_full, w_pop, w_space, w_accept, w_hit;
  logic              w_push, w_store_line;

  assign w_off    = r_pc[OFF_W-1:0];
  assign w_last   = &w_off;
  assign w_full   = (r_count == DEPTH_C);
  assign w_pop    = o_out_valid && i_out_ready && !i_redirect_valid;
  assign w_space  = !w_full || w_pop;
  assign w_hit    = r_line_valid && (r_line_tag == r_pc[ADDR_W-1:OFF_W]);

  // A full queue holds off the next line request so a response never has to wait in front of it.
  assign o_req_valid = (r_state == S_REQ) && !rst && !w_full;
  assign o_req_addr  = r_pc[ADDR_W-1:OFF_W];
  assign w_accept    = o_req_valid && i_req_ready;

  assign o_out_valid = (r_count != '0);
  assign o_out_pc    = r_q_pc[r_rptr];
  assign o_out_insn  = r_q_insn[r_rptr];

  always_comb begin
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      w_resp_words[i] = i_resp_data[32*i +: 32];
    end
    w_push_insn = (r_state == S_WAIT) ? w_resp_words[w_off] : r_line[w_off];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_store_line = 1'b0;
    case (r_state)
      S_REQ: begin
        if (i_redirect_valid)  w_state_next = w_accept ? S_FLUSH : S_REQ;
        else if (w_accept)     w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_redirect_valid) begin
          w_state_next = i_resp_valid ? S_REQ : S_FLUSH;
        end else if (i_resp_valid) begin
          w_store_line = 1'b1;
          w_push       = w_space;
          w_state_next = (w_space && w_last) ? S_REQ : S_RUN;
        end
      end
      S_RUN: begin
        if (i_redirect_valid || !w_hit) begin
          w_state_next = S_REQ;
        end else if (w_space) begin
          w_push = 1'b1;
          if (w_last) w_state_next = S_REQ;
        end
      end
      S_FLUSH: begin
        // The response to the abandoned request is the only thing still in flight.
        if (i_resp_valid) w_state_next = S_REQ;
      end
      default: w_state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_line_tag   <= '0;
      r_line_valid <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) r_line[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_insn[i] <= '0;
      end
    end else if (i_redirect_valid) begin
      r_pc         <= i_redirect_pc;
      r_line_valid <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      if (w_store_line) begin
        for (int i = 0; i < WORDS_PER_LINE; i++) r_line[i] <= w_resp_words[i];
        r_line_tag   <= r_pc[ADDR_W-1:OFF_W];
        r_line_valid <= 1'b1;
      end
      if (w_push) begin
        r_q_pc[r_wptr]   <= r_pc;
        r_q_insn[r_wptr] <= w_push_insn;
        r_wptr           <= r_wptr + PTR_W'(1);
        r_pc             <= r_pc + ADDR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                             o_perf_starve_cnt <= '0;
    else if (i_out_ready && !o_out_valid) o_perf_starve_cnt <= o_perf_starve_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a cache model answers line requests, a monitor checks every popped instruction.
module tb_ifetch_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_redirect_valid;
  logic [29:0]  i_redirect_pc;
  logic         o_req_valid;
  logic [27:0]  o_req_addr;
  logic         i_req_ready;
  logic         i_resp_valid;
  logic [127:0] i_resp_data;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [29:0]  o_out_pc;
  logic [31:0]  o_out_insn;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]  o_perf_starve_cnt;
`endif

  typedef struct {
    logic [29:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t        expQ[$];
  logic [27:0] expReq[$];
  int          popCyc[$];
  int          respCyc[$];
  int          vecCount = 0;
  int          missCount = 0;
  int          cyc = 0;
  int          cacheLat = 1;
  int          reqCount = 0;
  logic        cPend = 1'b0;
  int          cLeft = 0;
  logic [27:0] cAddr = '0;
  exp_t        monE;

  ifetch_queue #(
    .ADDR_W(30), .WORDS_PER_LINE(4), .FIFO_DEPTH(4), .RESET_PC(30'd0)
  ) dut (
    .clk(clk), .rst(rst),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_req_valid(o_req_valid), .o_req_addr(o_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_pc(o_out_pc),
`ifdef IFETCH_PERF_CNT_EN
    .o_perf_starve_cnt(o_perf_starve_cnt),
`endif
    .o_out_insn(o_out_insn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction image held by the cache model: word at address a is 0xA0 + a.
  function automatic logic [31:0] insnOf(input logic [29:0] pc);
    return 32'hA0 + {2'b00, pc};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic redirV, input logic [29:0] pcV, input logic readyV);
    @(negedge clk);
    rst              = rstV;
    i_redirect_valid = redirV;
    i_redirect_pc    = pcV;
    i_req_ready      = readyV;
  endtask

  task automatic pushExp(input logic [29:0] pc);
    exp_t e;
    e.pc   = pc;
    e.insn = insnOf(pc);
    expQ.push_back(e);
  endtask

  task automatic doReset();
    i_out_ready = 1'b0;
    repeat (8) applyStimulus(1'b1, 1'b0, '0, 1'b0);
    expQ.delete();
    expReq.delete();
    popCyc.delete();
    respCyc.delete();
    reqCount = 0;
  endtask

  // Downstream is ready only while the scoreboard still expects instructions.
  task automatic drain(input int maxCyc);
    int n = 0;
    forever begin
      @(negedge clk);
      if (expQ.size() == 0) begin
        i_out_ready = 1'b0;
        break;
      end
      if (n == maxCyc) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL drain timeout: got %0d entries left, expected 0", expQ.size());
        expQ.delete();
        i_out_ready = 1'b0;
        break;
      end
      i_out_ready = 1'b1;
      n++;
    end
  endtask

  task automatic checkGaps(input string name);
    for (int i = 1; i < popCyc.size(); i++) checkOutput(name, 64'(popCyc[i] - popCyc[i-1]), 64'd1);
  endtask

  // Cache model: one outstanding request, answered cacheLat cycles after acceptance.
  initial begin
    i_resp_valid = 1'b0;
    i_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      i_resp_valid = 1'b0;
      if (cPend) begin
        if (cLeft == 0) begin
          i_resp_valid = 1'b1;
          for (int i = 0; i < 4; i++) i_resp_data[32*i +: 32] = insnOf({cAddr, 2'(i)});
          cPend = 1'b0;
          respCyc.push_back(cyc);
        end else begin
          cLeft--;
        end
      end
      if (o_req_valid && i_req_ready) begin
        reqCount++;
        cPend = 1'b1;
        cAddr = o_req_addr;
        cLeft = cacheLat - 1;
        if (expReq.size() > 0) checkOutput("req_addr", 64'(o_req_addr), 64'(expReq.pop_front()));
      end
    end
  end

  // Monitor: every pop the DUT will perform at the next edge is compared with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (o_out_valid && i_out_ready && !i_redirect_valid) begin
        popCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL unexpected pop: got pc 0x%0h, expected no output", o_out_pc);
        end else begin
          monE = expQ.pop_front();
          checkOutput("out_pc", 64'(o_out_pc), 64'(monE.pc));
          checkOutput("out_insn", 64'(o_out_insn), 64'(monE.insn));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_redirect_valid = 1'b0;
    i_redirect_pc = '0;
    i_req_ready = 1'b0;
    i_out_ready = 1'b0;

    // Reset state, then one line streamed back to back followed by the next line request.
    doReset();
    #1;
    checkOutput("rst req_valid", 64'(o_req_valid), 64'd0);
    checkOutput("rst out_valid", 64'(o_out_valid), 64'd0);
    checkOutput("rst out_pc", 64'(o_out_pc), 64'd0);
    checkOutput("rst out_insn", 64'(o_out_insn), 64'd0);
    cacheLat = 1;
    for (int p = 0; p < 4; p++) pushExp(30'(p));
    expReq.push_back(28'd0);
    expReq.push_back(28'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("first req_valid", 64'(o_req_valid), 64'd1);
    checkOutput("first req_addr", 64'(o_req_addr), 64'd0);
    drain(50);
    if (popCyc.size() > 0 && respCyc.size() > 0)
      checkOutput("resp to out latency", 64'(popCyc[0] - respCyc[0]), 64'd1);
    else
      checkOutput("resp to out seen", 64'(popCyc.size()), 64'd4);
    checkGaps("line0 back-to-back");
    repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("line0 reqs left", 64'(expReq.size()), 64'd0);

    // Stalled consumer: exactly one line fills the queue, then no request until space opens.
    doReset();
    cacheLat = 1;
    repeat (13) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("full out_valid", 64'(o_out_valid), 64'd1);
    checkOutput("full out_pc", 64'(o_out_pc), 64'd0);
    checkOutput("full out_insn", 64'(o_out_insn), 64'hA0);
    checkOutput("full req_valid", 64'(o_req_valid), 64'd0);
    checkOutput("full next line", 64'(o_req_addr), 64'd1);
    checkOutput("full req count", 64'(reqCount), 64'd1);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("stalled head pc", 64'(o_out_pc), 64'd0);
    for (int p = 0; p < 8; p++) pushExp(30'(p));
    expReq.push_back(28'd1);
    drain(60);
    checkGaps("refill no gaps");
    repeat (4) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("refill reqs left", 64'(expReq.size()), 64'd0);

    // Redirect while waiting for a line: the stale response must be dropped.
    doReset();
    cacheLat = 4;
    expReq.push_back(28'd0);
    expReq.push_back(28'h41);
    expReq.push_back(28'h42);
    pushExp(30'h106);
    pushExp(30'h107);
    pushExp(30'h108);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 30'h106, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("flush out_valid", 64'(o_out_valid), 64'd0);
    checkOutput("flush req_valid", 64'(o_req_valid), 64'd0);
    repeat (20) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    drain(40);
    checkOutput("redirect reqs left", 64'(expReq.size()), 64'd0);

    // Redirect to the last word of the address space: PC wraps to line 0.
    doReset();
    cacheLat = 1;
    expReq.push_back(28'hFFFFFFF);
    expReq.push_back(28'h0);
    pushExp(30'h3FFFFFFF);
    pushExp(30'h0);
    pushExp(30'h1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 30'h3FFFFFFF, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    #1;
    checkOutput("wrap req_valid", 64'(o_req_valid), 64'd1);
    checkOutput("wrap req_addr", 64'(o_req_addr), 64'hFFFFFFF);
    repeat (6) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    drain(40);
    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("wrap reqs left", 64'(expReq.size()), 64'd0);

`ifdef IFETCH_PERF_CNT_EN
    // Starved cycles from reset release until the first instruction appears.
    doReset();
    cacheLat = 6;
    pushExp(30'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    i_out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (o_out_valid) break;
    end
    checkOutput("perf out_valid", 64'(o_out_valid), 64'd1);
    checkOutput("perf starve cnt", 64'(o_perf_starve_cnt), 64'd7);
    drain(10);
`endif

    repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
